// File: rtl/game_ctrl.sv
// game_ctrl: game-flow sequencer for a maze game.
// It tracks the attract/ready/play/pause/death/clear/over phases, the lives
// and level counters, and a frame-based dwell timer. Its Moore outputs gate
// gameplay motion and drive the HUD.
module game_ctrl #(
  parameter int               KEY_W        = 8,
  parameter logic [KEY_W-1:0] KEY_START    = KEY_W'(8'h2C),
  parameter logic [KEY_W-1:0] KEY_PAUSE    = KEY_W'(8'h13),
  parameter int               LIVES        = 3,
  parameter int               LEVELS       = 8,
  parameter int               READY_FRAMES = 120,
  parameter int               DEATH_FRAMES = 90,
  parameter int               CLEAR_FRAMES = 60,
  parameter int               OVER_FRAMES  = 180
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [KEY_W-1:0]          keycode,
  input  logic                      frame_tick,
  input  logic                      pellets_clear,
  input  logic                      caught,
  output logic                      start,
  output logic                      stop,
  output logic                      paused,
  output logic [2:0]                state,
  output logic [3:0]                lives,
  output logic [$clog2(LEVELS)-1:0] level,
  output logic                      level_up,
  output logic                      game_over
);

  localparam int LVL_W = $clog2(LEVELS);

  // Dwell reload values, narrowed once to the 12-bit timer width
  localparam logic [11:0] T_READY = 12'(READY_FRAMES);
  localparam logic [11:0] T_DEATH = 12'(DEATH_FRAMES);
  localparam logic [11:0] T_CLEAR = 12'(CLEAR_FRAMES);
  localparam logic [11:0] T_OVER  = 12'(OVER_FRAMES);
  localparam logic [3:0]  L_INIT  = 4'(LIVES);
  localparam logic [LVL_W-1:0] L_LAST = LVL_W'(LEVELS - 1);

  typedef enum logic [2:0] {
    S_ATTRACT = 3'd0,
    S_READY   = 3'd1,
    S_PLAY    = 3'd2,
    S_PAUSE   = 3'd3,
    S_DEATH   = 3'd4,
    S_CLEAR   = 3'd5,
    S_OVER    = 3'd6,
    S_BAD     = 3'd7
  } state_t;

  state_t           state_reg, state_next;
  logic [11:0]      timer_reg, timer_next;
  logic [3:0]       lives_reg, lives_next;
  logic [LVL_W-1:0] level_reg, level_next;
  logic             level_up_reg, level_up_next;
  logic [KEY_W-1:0] prev_key_reg;

  logic key_changed;
  logic start_press;
  logic pause_press;
  logic dwell;
  logic expire;

  // A held key counts once: only the cycle where the code first appears is a press
  assign key_changed = (keycode != prev_key_reg);
  assign start_press = key_changed && (keycode == KEY_START);
  assign pause_press = key_changed && (keycode == KEY_PAUSE);

  // Timer only runs in the four timed phases; expiry is the tick seen at count 1
  assign dwell  = (state_reg == S_READY) || (state_reg == S_DEATH) ||
                  (state_reg == S_CLEAR) || (state_reg == S_OVER);
  assign expire = frame_tick && (timer_reg == 12'd1);

  // State, counters, timer and previous keycode registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_ATTRACT;
      timer_reg    <= 12'd0;
      lives_reg    <= 4'd0;
      level_reg    <= '0;
      level_up_reg <= 1'b0;
      prev_key_reg <= '0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      lives_reg    <= lives_next;
      level_reg    <= level_next;
      level_up_reg <= level_up_next;
      prev_key_reg <= keycode;
    end
  end

  // Next-state, counter updates and timer loads; an entry load overrides the tick decrement
  always_comb begin
    state_next    = state_reg;
    timer_next    = timer_reg;
    lives_next    = lives_reg;
    level_next    = level_reg;
    level_up_next = 1'b0;

    if (dwell && frame_tick && (timer_reg != 12'd0)) begin
      timer_next = timer_reg - 12'd1;
    end

    case (state_reg)
      S_ATTRACT: begin
        if (start_press) begin
          state_next = S_READY;
          lives_next = L_INIT;
          level_next = '0;
          timer_next = T_READY;
        end
      end

      S_READY: begin
        if (expire) begin
          state_next = S_PLAY;
        end
      end

      S_PLAY: begin
        // Being caught outranks finishing the maze, which outranks pausing
        if (caught) begin
          state_next = S_DEATH;
          lives_next = (lives_reg != 4'd0) ? (lives_reg - 4'd1) : 4'd0;
          timer_next = T_DEATH;
        end else if (pellets_clear) begin
          state_next = S_CLEAR;
          timer_next = T_CLEAR;
        end else if (pause_press) begin
          state_next = S_PAUSE;
        end
      end

      S_PAUSE: begin
        if (pause_press) begin
          state_next = S_PLAY;
        end
      end

      S_DEATH: begin
        if (expire) begin
          if (lives_reg == 4'd0) begin
            state_next = S_OVER;
            timer_next = T_OVER;
          end else begin
            state_next = S_READY;
            timer_next = T_READY;
          end
        end
      end

      S_CLEAR: begin
        if (expire) begin
          state_next    = S_READY;
          timer_next    = T_READY;
          level_up_next = 1'b1;
          level_next    = (level_reg == L_LAST) ? '0 : (level_reg + 1'b1);
        end
      end

      S_OVER: begin
        // Lives and level are left showing until the next game starts
        if (start_press || expire) begin
          state_next = S_ATTRACT;
        end
      end

      default: begin
        state_next = S_ATTRACT;
      end
    endcase
  end

  // Moore output decode
  assign start     = (state_reg == S_PLAY);
  assign stop      = ~start;
  assign paused    = (state_reg == S_PAUSE);
  assign game_over = (state_reg == S_OVER);
  assign state     = state_reg;
  assign lives     = lives_reg;
  assign level     = level_reg;
  assign level_up  = level_up_reg;

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: scoreboard bench for game_ctrl. Each driven cycle pushes
// the expected outputs from a rule-level reference model. A free-running
// monitor pops those entries and compares them with the DUT. Directed
// checks with constant expectations cover the named scenarios.
module tb_game_ctrl;

  localparam int P_READY  = 2;
  localparam int P_DEATH  = 2;
  localparam int P_CLEAR  = 1;
  localparam int P_OVER   = 3;
  localparam int P_LIVES  = 2;
  localparam int P_LEVELS = 2;
  localparam logic [7:0] K_START = 8'h2C;
  localparam logic [7:0] K_PAUSE = 8'h13;

  // Phase numbering as seen on the state output
  localparam int ATTRACT = 0, READY = 1, PLAY = 2, PAUSE = 3, DEATH = 4, CLEAR = 5, OVER = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       frame_tick = 1'b0;
  logic       pellets_clear = 1'b0;
  logic       caught = 1'b0;
  logic       start, stop, paused, level_up, game_over;
  logic [2:0] state;
  logic [3:0] lives;
  logic [0:0] level;

  always #5 clk = ~clk;

  game_ctrl #(
    .KEY_W(8), .KEY_START(K_START), .KEY_PAUSE(K_PAUSE),
    .LIVES(P_LIVES), .LEVELS(P_LEVELS),
    .READY_FRAMES(P_READY), .DEATH_FRAMES(P_DEATH),
    .CLEAR_FRAMES(P_CLEAR), .OVER_FRAMES(P_OVER)
  ) dut (
    .clk(clk), .rst_n(rst_n), .keycode(keycode), .frame_tick(frame_tick),
    .pellets_clear(pellets_clear), .caught(caught),
    .start(start), .stop(stop), .paused(paused), .state(state),
    .lives(lives), .level(level), .level_up(level_up), .game_over(game_over)
  );

  typedef struct packed {
    logic [2:0] st;
    logic [3:0] lv;
    logic [0:0] lvl;
    logic       up;
    logic       run;
    logic       frz;
    logic       pau;
    logic       go;
  } obs_t;

  obs_t exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int up_count = 0;
  bit hold_rst = 1'b0;

  // Reference model: game phase, lives, level, frames left in a timed phase
  int m_mode, m_lives, m_level, m_left, m_prev;
  bit m_up;

  task automatic model_reset();
    m_mode = ATTRACT; m_lives = 0; m_level = 0; m_left = 0; m_prev = 0; m_up = 0;
  endtask

  task automatic enter(input int mode, input int frames);
    m_mode = mode;
    m_left = frames;
  endtask

  // One clock of game rules applied to the inputs present at that edge
  task automatic model_step(input logic [7:0] k, input logic t, input logic p, input logic c);
    bit sp, pp, timed, expired;
    sp = (k == K_START) && (int'(k) != m_prev);
    pp = (k == K_PAUSE) && (int'(k) != m_prev);
    timed = (m_mode == READY) || (m_mode == DEATH) || (m_mode == CLEAR) || (m_mode == OVER);
    expired = timed && t && (m_left == 1);
    m_prev = int'(k);
    m_up = 0;
    if (timed && t && m_left > 0) m_left = m_left - 1;
    if (m_mode == ATTRACT && sp) begin
      m_lives = P_LIVES; m_level = 0; enter(READY, P_READY);
    end else if (m_mode == READY && expired) begin
      m_mode = PLAY;
    end else if (m_mode == PLAY) begin
      if (c) begin
        m_lives = (m_lives > 0) ? m_lives - 1 : 0;
        enter(DEATH, P_DEATH);
      end else if (p) enter(CLEAR, P_CLEAR);
      else if (pp) m_mode = PAUSE;
    end else if (m_mode == PAUSE && pp) begin
      m_mode = PLAY;
    end else if (m_mode == DEATH && expired) begin
      if (m_lives == 0) enter(OVER, P_OVER);
      else enter(READY, P_READY);
    end else if (m_mode == CLEAR && expired) begin
      m_level = (m_level + 1) % P_LEVELS;
      m_up = 1;
      enter(READY, P_READY);
    end else if (m_mode == OVER && (sp || expired)) begin
      m_mode = ATTRACT;
    end
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.st  = 3'(m_mode);
    o.lv  = 4'(m_lives);
    o.lvl = 1'(m_level);
    o.up  = m_up;
    o.run = (m_mode == PLAY);
    o.frz = (m_mode != PLAY);
    o.pau = (m_mode == PAUSE);
    o.go  = (m_mode == OVER);
    return o;
  endfunction

  // Monitor: compare the DUT against the oldest expectation after every edge
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (level_up) up_count++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {state, lives, level, level_up, start, stop, paused, game_over};
        n_checks++;
        if (a !== e) begin
          n_errors++;
          $display("FAIL scoreboard t=%0t: got st=%0d lives=%0d lvl=%0d up=%0b start=%0b stop=%0b pau=%0b go=%0b required st=%0d lives=%0d lvl=%0d up=%0b start=%0b stop=%0b pau=%0b go=%0b",
                   $time, a.st, a.lv, a.lvl, a.up, a.run, a.frz, a.pau, a.go,
                   e.st, e.lv, e.lvl, e.up, e.run, e.frz, e.pau, e.go);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int req);
    n_checks++;
    if (got != req) begin
      n_errors++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  // Drive one cycle of inputs and queue the expected result of that edge
  task automatic cyc(input logic [7:0] k, input logic t, input logic p, input logic c);
    @(negedge clk);
    rst_n = ~hold_rst;
    keycode = k; frame_tick = t; pellets_clear = p; caught = c;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(k, t, p, c);
    exp_q.push_back(model_obs());
    $display("cycle key=%02h tick=%0b pel=%0b caught=%0b rst_n=%0b -> expect st=%0d lives=%0d lvl=%0d",
             k, t, p, c, rst_n, m_mode, m_lives, m_level);
  endtask

  task automatic cyc_n(input int n, input logic [7:0] k, input logic t, input logic p, input logic c);
    for (int i = 0; i < n; i++) cyc(k, t, p, c);
  endtask

  // Let the monitor finish with this edge before reading outputs directly
  task automatic settle();
    #2;
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_state"}, int'(state), ATTRACT);
    chk({tag, "_start_stop"}, int'({start, stop}), 1);
    chk({tag, "_flags"}, int'({paused, game_over, level_up}), 0);
    chk({tag, "_lives_level"}, int'({lives, level}), 0);
  endtask

  // Assert reset between clock edges and check that the outputs react at once
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    reset_chk(tag);
    model_reset();
    hold_rst = 1'b1;
    cyc(8'h00, 1'b0, 1'b0, 1'b0);
    hold_rst = 1'b0;
  endtask

  initial begin
    int up0, r;
    logic [7:0] k;
    model_reset();
    #1;
    reset_chk("por");
    hold_rst = 1'b1;
    cyc_n(2, 8'h00, 1'b0, 1'b0, 1'b0);
    hold_rst = 1'b0;

    // Held start key is a single press; two ticks later gameplay runs
    cyc_n(10, K_START, 1'b0, 1'b0, 1'b0);
    settle(); chk("held_start_ready", int'(state), READY);
    cyc_n(2, 8'h00, 1'b1, 1'b0, 1'b0);
    settle();
    chk("ready_to_play", int'(state), PLAY);
    chk("play_start", int'(start), 1);
    chk("play_lives", int'(lives), 2);

    // Caught and maze-clear together: caught wins
    cyc(8'h00, 1'b0, 1'b1, 1'b1);
    settle();
    chk("prio_state", int'(state), DEATH);
    chk("prio_lives", int'(lives), 1);
    chk("prio_level", int'(level), 0);

    // Second death runs out of lives into game over, then times out
    cyc_n(4, 8'h00, 1'b1, 1'b0, 1'b0);
    settle(); chk("respawn_play", int'(state), PLAY);
    cyc(8'h00, 1'b0, 1'b0, 1'b1);
    cyc_n(2, 8'h00, 1'b1, 1'b0, 1'b0);
    settle();
    chk("over_state", int'(state), OVER);
    chk("over_flag", int'(game_over), 1);
    cyc_n(2, 8'h00, 1'b1, 1'b0, 1'b0);
    settle(); chk("over_dwell", int'(state), OVER);
    cyc(8'h00, 1'b1, 1'b0, 1'b0);
    settle();
    chk("over_expire", int'(state), ATTRACT);
    chk("over_lives_held", int'(lives), 0);

    // Two level clears wrap the level and pulse level_up once each
    up0 = up_count;
    cyc(K_START, 1'b0, 1'b0, 1'b0);
    cyc_n(2, 8'h00, 1'b1, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b1, 1'b0);
    settle(); chk("clear_state", int'(state), CLEAR);
    cyc(8'h00, 1'b1, 1'b0, 1'b0);
    settle();
    chk("clear1_level", int'(level), 1);
    chk("clear1_up", int'(level_up), 1);
    cyc(8'h00, 1'b0, 1'b0, 1'b0);
    settle(); chk("clear1_up_drop", int'(level_up), 0);
    cyc_n(2, 8'h00, 1'b1, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b1, 1'b0);
    cyc(8'h00, 1'b1, 1'b0, 1'b0);
    settle(); chk("clear2_level_wrap", int'(level), 0);
    cyc(8'h00, 1'b0, 1'b0, 1'b0);
    settle(); chk("level_up_pulses", up_count - up0, 2);

    // Pause freezes everything, including caught and frame ticks
    cyc_n(2, 8'h00, 1'b1, 1'b0, 1'b0);
    cyc(K_PAUSE, 1'b0, 1'b0, 1'b0);
    settle(); chk("pause_paused", int'(paused), 1);
    for (int i = 0; i < 5; i++) begin
      cyc(8'h00, 1'b1, 1'b0, 1'b1);
      settle();
      chk("pause_hold_state", int'(state), PAUSE);
      chk("pause_hold_lives", int'(lives), 2);
    end
    cyc(K_PAUSE, 1'b0, 1'b0, 1'b0);
    settle(); chk("unpause_state", int'(state), PLAY);

    // Reset in DEATH, then a fresh start press
    cyc(8'h00, 1'b0, 1'b0, 1'b1);
    settle(); chk("pre_reset_death", int'(state), DEATH);
    pulse_reset("mid_reset");
    cyc(8'h00, 1'b0, 1'b0, 1'b0);
    settle(); chk("post_reset_idle", int'(state), ATTRACT);
    cyc(K_START, 1'b0, 1'b0, 1'b0);
    settle(); chk("post_reset_start", int'(state), READY);

    // Randomised play against the model
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 7);
      if (r < 3) k = 8'h00;
      else if (r < 5) k = K_START;
      else if (r < 7) k = K_PAUSE;
      else k = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 399) == 0) pulse_reset("rand_reset");
      else cyc(k, ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 15) == 0));
    end

    repeat (3) @(posedge clk);
    settle();
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
